// File: rtl/panel_power_seq.sv
// Panel power sequencer: brings an LCD panel up (timing -> DISP -> backlight)
// and down (backlight -> DISP -> timing) with cycle- and frame-based delays.
module panel_power_seq #(
    parameter int T_PWR_CYC    = 500_000,
    parameter int FRAMES_ON    = 10,
    parameter int T_BL_OFF_CYC = 250_000,
    parameter int FRAMES_OFF   = 2
) (
    input  logic       clk_pix,
    input  logic       rst,
    input  logic       power_req,
    input  logic       vsync_start,
    output logic       timing_en,
    output logic       disp_en,
    output logic       blank,
    output logic       bl_en,
    output logic       ready,
    output logic [2:0] state
);

    localparam int T_PWR   = (T_PWR_CYC    < 1) ? 1 : T_PWR_CYC;
    localparam int T_BL    = (T_BL_OFF_CYC < 1) ? 1 : T_BL_OFF_CYC;
    localparam int FR_ON   = (FRAMES_ON    < 1) ? 1 : FRAMES_ON;
    localparam int FR_OFF  = (FRAMES_OFF   < 1) ? 1 : FRAMES_OFF;
    localparam int CYC_MAX = (T_PWR > T_BL) ? T_PWR : T_BL;
    localparam int FRM_MAX = (FR_ON > FR_OFF) ? FR_ON : FR_OFF;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int FRM_W   = $clog2(FRM_MAX + 1);

    localparam logic [CYC_W-1:0] PWR_LAST    = CYC_W'(T_PWR - 1);
    localparam logic [CYC_W-1:0] BL_LAST     = CYC_W'(T_BL - 1);
    localparam logic [FRM_W-1:0] FR_ON_LAST  = FRM_W'(FR_ON - 1);
    localparam logic [FRM_W-1:0] FR_OFF_LAST = FRM_W'(FR_OFF - 1);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_SIG_ON   = 3'd1,
        ST_DISP_ON  = 3'd2,
        ST_RUN      = 3'd3,
        ST_BL_OFF   = 3'd4,
        ST_DISP_OFF = 3'd5
    } state_t;

    // Output bundle order: {timing_en, disp_en, blank, bl_en, ready}
    localparam logic [4:0] OUT_OFF = 5'b00100;

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic [4:0]       out_q, out_d;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            cyc_q   <= '0;
            frm_q   <= '0;
            out_q   <= OUT_OFF;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            frm_q   <= frm_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        frm_d   = frm_q;
        case (state_q)
            ST_OFF: begin
                if (power_req) state_d = ST_SIG_ON;
            end
            ST_SIG_ON: begin
                cyc_d = cyc_q + 1'b1;
                if (!power_req)             state_d = ST_OFF;
                else if (cyc_q == PWR_LAST) state_d = ST_DISP_ON;
            end
            ST_DISP_ON: begin
                if (vsync_start) frm_d = frm_q + 1'b1;
                if (!power_req)                              state_d = ST_DISP_OFF;
                else if (vsync_start && frm_q == FR_ON_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!power_req) state_d = ST_BL_OFF;
            end
            ST_BL_OFF: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == BL_LAST) state_d = ST_DISP_OFF;
            end
            ST_DISP_OFF: begin
                if (vsync_start) frm_d = frm_q + 1'b1;
                if (vsync_start && frm_q == FR_OFF_LAST) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
        // Counters restart from zero in every newly entered state
        if (state_d != state_q) begin
            cyc_d = '0;
            frm_d = '0;
        end
    end

    // Outputs are decoded from the next state so they register with it
    always_comb begin
        out_d = OUT_OFF;
        case (state_d)
            ST_OFF:      out_d = 5'b00100;
            ST_SIG_ON:   out_d = 5'b10100;
            ST_DISP_ON:  out_d = 5'b11100;
            ST_RUN:      out_d = 5'b11011;
            ST_BL_OFF:   out_d = 5'b11100;
            ST_DISP_OFF: out_d = 5'b10100;
            default:     out_d = OUT_OFF;
        endcase
    end

    assign {timing_en, disp_en, blank, bl_en, ready} = out_q;
    assign state = state_q;

endmodule

// File: doc/panel_power_seq.md
PANEL_POWER_SEQ -- requirements
Module: panel_power_seq

Interface
REQ-001 SHALL have parameter T_PWR_CYC, default 500_000, giving clk_pix cycles from timing start to disp_en (10 ms at 50 MHz).
REQ-002 SHALL have parameter FRAMES_ON, default 10, giving vsync_start pulses counted with disp_en high before backlight on.
REQ-003 SHALL have parameter T_BL_OFF_CYC, default 250_000, giving clk_pix cycles from backlight off to disp_en low.
REQ-004 SHALL have parameter FRAMES_OFF, default 2, giving vsync_start pulses counted with disp_en low before timing stops.
REQ-005 SHALL have port clk_pix, input, 1 bit: the single pixel clock; all logic sits in this domain.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port power_req, input, 1 bit: level request; 1 = panel on, 0 = panel off.
REQ-008 SHALL have port vsync_start, input, 1 bit: one-cycle pulse at frame start from the timing generator.
REQ-009 SHALL have port timing_en, output, 1 bit: enables the timing generator and dclk.
REQ-010 SHALL have port disp_en, output, 1 bit: panel DISP pin.
REQ-011 SHALL have port blank, output, 1 bit: forces RGB to black downstream.
REQ-012 SHALL have port bl_en, output, 1 bit: backlight enable.
REQ-013 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-014 SHALL have port state, output, 3 bits: encoding OFF=0, SIG_ON=1, DISP_ON=2, RUN=3, BL_OFF=4, DISP_OFF=5.

Function
REQ-015 SHALL drive every output from a register; outputs change on the same clk_pix edge as the state register.
REQ-016 SHALL drive these outputs per state (timing_en, disp_en, blank, bl_en, ready):
  - OFF: 0,0,1,0,0
  - SIG_ON: 1,0,1,0,0
  - DISP_ON: 1,1,1,0,0
  - RUN: 1,1,0,1,1
  - BL_OFF: 1,1,1,0,0
  - DISP_OFF: 1,0,1,0,0
REQ-017 SHALL move OFF->SIG_ON on the edge after power_req is sampled 1 in OFF.
REQ-018 SHALL stay in SIG_ON exactly T_PWR_CYC cycles, then move to DISP_ON; if power_req is sampled 0 in SIG_ON it SHALL move to OFF on the next edge.
REQ-019 SHALL, in DISP_ON, move to RUN on the edge after the FRAMES_ON-th counted vsync_start; if power_req is sampled 0 it SHALL move to DISP_OFF on the next edge.
REQ-020 SHALL move RUN->BL_OFF on the edge after power_req is sampled 0.
REQ-021 SHALL stay in BL_OFF exactly T_BL_OFF_CYC cycles, then move to DISP_OFF, regardless of power_req.
REQ-022 SHALL, in DISP_OFF, move to OFF on the edge after the FRAMES_OFF-th counted vsync_start, regardless of power_req; if power_req is 1 there, OFF then restarts per REQ-017.
REQ-023 SHALL count vsync_start only on cycles where the state register already holds the counting state; a pulse on the entry edge is not counted.
REQ-024 SHALL clear the cycle counter and the frame counter on every state transition.
REQ-025 SHALL size each counter as $clog2(param+1) bits so that it never wraps.
REQ-026 SHALL treat a parameter value of 0 as 1.
REQ-027 SHALL map any illegal state encoding to OFF on the next edge.

Reset
REQ-028 SHALL, while rst=1, asynchronously force state=OFF, zero both counters, and drive timing_en=0, disp_en=0, blank=1, bl_en=0, ready=0.
REQ-029 SHALL, on rst asserted mid-sequence (any state), drop bl_en and disp_en immediately without a power-down sequence; after rst falls it SHALL start in OFF.

Verification
Bench parameters for all scenarios: T_PWR_CYC=8, FRAMES_ON=2, T_BL_OFF_CYC=4, FRAMES_OFF=1; vsync_start pulses every 20 cycles.
REQ-030 SHALL cover power-up: power_req 0->1 -> SIG_ON for exactly 8 cycles, then DISP_ON; RUN (bl_en=1, blank=0, ready=1) on the edge after the 2nd counted vsync_start.
REQ-031 SHALL cover power-down: power_req 1->0 in RUN -> BL_OFF (bl_en=0, blank=1) for exactly 4 cycles, then DISP_OFF (disp_en=0), then OFF (timing_en=0) on the edge after the next vsync_start.
REQ-032 SHALL cover abort in SIG_ON: power_req drops at SIG_ON cycle 3 -> state=OFF next edge; disp_en never asserted.
REQ-033 SHALL cover a re-request during power-down: power_req 0->1 during BL_OFF -> BL_OFF and DISP_OFF complete unchanged, OFF held 1 cycle, then SIG_ON.
REQ-034 SHALL cover the vsync entry boundary: vsync_start coincides with the DISP_ON entry edge -> it is not counted; RUN requires 2 later pulses.
REQ-035 SHALL cover async reset: rst pulsed mid-cycle while in RUN -> bl_en=0, disp_en=0, timing_en=0, state=0 before the next clk_pix edge.
